// File: rtl/ifmap_window_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifmap_window_gen_pkg
// Description : Shared constants for the 3x3 ifmap window generator and the
//               PE tensor. Both sides pack a 3x3 window into bytes using the
//               same byte index k = 3*r + c (r=0 top/oldest row, c=0
//               leftmost/oldest column).
// Contents    : DATA_W, KERNEL_DIM, WIN_W, win_byte_idx()
// Revision    : 1.0 - initial release
// ============================================================================
package ifmap_window_gen_pkg;

  localparam int DATA_W     = 8;
  localparam int KERNEL_DIM = 3;
  localparam int WIN_W      = KERNEL_DIM * KERNEL_DIM * DATA_W;

  // Byte slot of window element (r, c) inside the packed operand.
  function automatic int win_byte_idx(input int r, input int c);
    return KERNEL_DIM * r + c;
  endfunction

endpackage : ifmap_window_gen_pkg
`default_nettype wire

// File: rtl/ifmap_window_gen_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : ifmap_window_gen_line_buffer
// Description : DEPTH-deep shift FIFO. Each enabled edge shifts data_i in at
//               the head; tap_o is the element shifted in DEPTH enables ago,
//               i.e. the pixel one image row above when DEPTH = image width.
//               Storage is deliberately not reset.
// Ports       : clk        - clock
//               shift_en_i - shift one element in this edge
//               data_i     - element shifted in
//               tap_o      - oldest element (registered storage output)
// Revision    : 1.0 - initial release
// ============================================================================
module ifmap_window_gen_line_buffer #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = ifmap_window_gen_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              shift_en_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] tap_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (shift_en_i) begin
      mem_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        mem_q[i] <= mem_q[i-1];
      end
    end
  end

  assign tap_o = mem_q[DEPTH-1];

endmodule : ifmap_window_gen_line_buffer
`default_nettype wire

// File: rtl/ifmap_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : ifmap_window_gen
// Description : Streaming 3x3 sliding-window generator. Accepts one raster-
//               order pixel per cycle, keeps two line buffers and a 3x3
//               window register, and emits one packed window for every
//               pixel position with row >= 2 and col >= 2.
// Ports       : clk        - clock
//               rst        - asynchronous reset, active low
//               pix_valid  - pixel_in valid
//               pix_ready  - generator accepts a pixel this cycle
//               pixel_in   - raster-order pixel
//               win_valid  - ifmap holds an unconsumed window
//               win_ready  - downstream consumes the window this cycle
//               ifmap      - packed window, byte k = 3*r + c
//               frame_done - one-cycle pulse after last pixel is accepted
// Revision    : 1.0 - initial release
// ============================================================================
module ifmap_window_gen
  import ifmap_window_gen_pkg::*;
#(
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8,
  parameter int DATA_W = ifmap_window_gen_pkg::DATA_W
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   pix_valid,
  output logic                                   pix_ready,
  input  logic [DATA_W-1:0]                      pixel_in,
  output logic                                   win_valid,
  input  logic                                   win_ready,
  output logic [KERNEL_DIM*KERNEL_DIM*DATA_W-1:0] ifmap,
  output logic                                   frame_done
);

  localparam int WIN_BITS = KERNEL_DIM * KERNEL_DIM * DATA_W;
  localparam int COL_W    = $clog2(IMG_W);
  localparam int ROW_W    = $clog2(IMG_H);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(KERNEL_DIM - 1);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(KERNEL_DIM - 1);

  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [DATA_W-1:0]   win_q [KERNEL_DIM][KERNEL_DIM];
  logic [DATA_W-1:0]   win_d [KERNEL_DIM][KERNEL_DIM];
  logic [WIN_BITS-1:0] ifmap_q, ifmap_d;
  logic                win_valid_q, win_valid_d;
  logic                frame_done_q, frame_done_d;

  logic                accept;
  logic                emit;
  logic [DATA_W-1:0]   lb0_tap;
  logic [DATA_W-1:0]   lb1_tap;
  logic [DATA_W-1:0]   new_col [KERNEL_DIM];

  // Input stalls only while an unconsumed window is held.
  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;

  // Row/col gating guarantees every emitted window lies entirely inside the
  // current frame, so stale line-buffer contents never reach ifmap.
  assign emit = accept && (row_q >= ROW_MIN) && (col_q >= COL_MIN);

  // lb0 tap is the pixel one row above, lb1 tap the pixel two rows above.
  ifmap_window_gen_line_buffer #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W)
  ) u_lb0 (
    .clk        (clk),
    .shift_en_i (accept),
    .data_i     (pixel_in),
    .tap_o      (lb0_tap)
  );

  ifmap_window_gen_line_buffer #(
    .DEPTH  (IMG_W),
    .DATA_W (DATA_W)
  ) u_lb1 (
    .clk        (clk),
    .shift_en_i (accept),
    .data_i     (lb0_tap),
    .tap_o      (lb1_tap)
  );

  // Incoming right column: oldest row at r=0.
  assign new_col[0] = lb1_tap;
  assign new_col[1] = lb0_tap;
  assign new_col[2] = pixel_in;

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    ifmap_d      = ifmap_q;
    frame_done_d = 1'b0;
    win_valid_d  = win_valid_q;

    if (accept) begin
      for (int r = 0; r < KERNEL_DIM; r++) begin
        for (int c = 0; c < KERNEL_DIM - 1; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
        win_d[r][KERNEL_DIM-1] = new_col[r];
      end

      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // A new window takes priority over consumption of the current one.
    if (emit) begin
      win_valid_d = 1'b1;
      for (int r = 0; r < KERNEL_DIM; r++) begin
        for (int c = 0; c < KERNEL_DIM; c++) begin
          ifmap_d[win_byte_idx(r, c)*DATA_W +: DATA_W] = win_d[r][c];
        end
      end
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      ifmap_q      <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < KERNEL_DIM; r++) begin
        for (int c = 0; c < KERNEL_DIM; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      ifmap_q      <= ifmap_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  assign ifmap      = ifmap_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule : ifmap_window_gen
`default_nettype wire

// File: doc/ifmap_window_gen.md
# ifmap_window_gen

Streaming 3x3 sliding-window generator that produces the 72-bit ifmap operand consumed by the 3x3 PE tensor. It accepts one 8-bit pixel per cycle in raster order with a valid/ready handshake. It keeps two line buffers plus a 3x3 window register. For every pixel position whose row and column are both at least 2, it emits one packed 3x3 window. It sits between the activation memory reader and the PE tensor's ifmap input.

## Interface
- IMG_W, 8, image width in pixels (≥3)
- IMG_H, 8, image height in pixels (≥3)
- DATA_W, 8, pixel width; window width is 9*DATA_W

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- pix_valid  in  1  pixel_in is valid this cycle
- pix_ready  out  1  generator can accept a pixel this cycle
- pixel_in  in  DATA_W  raster-order pixel
- win_valid  out  1  ifmap holds a valid window
- win_ready  in  1  downstream consumes the window this cycle
- ifmap  out  9*DATA_W  packed window; byte k = 3*r + c, r=0 top (oldest) row, c=0 leftmost (oldest) column
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is accepted

## Operation
- Accept: pixel is accepted when pix_valid && pix_ready.
- pix_ready = !win_valid || win_ready, combinational. Input stalls only while an unconsumed window is held.
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) track the position of the accepted pixel.
  - col wraps to 0 after IMG_W-1 and row increments.
  - Both wrap to 0 after (IMG_H-1, IMG_W-1), and frame_done pulses in that cycle.
- On accept:
  - line buffer 0 shifts in pixel_in.
  - line buffer 1 shifts in line buffer 0's output, which is the pixel one row above.
  - The window register columns shift left. The new right column becomes {lb1_out, lb0_out, pixel_in}, mapped to rows r=0,1,2.
- Window emission: if the accepted pixel has row ≥ 2 and col ≥ 2, win_valid is set on the next edge and ifmap is loaded from the updated window register.
  - No window is emitted for col 0/1 or row 0/1. Stale data straddling a row boundary is never emitted.
  - Windows per frame: (IMG_W-2)*(IMG_H-2).
- Consume: win_valid clears on the edge where win_valid && win_ready, unless the same edge accepts a pixel that produces a new window. In that case win_valid stays 1 and ifmap updates.
- Back-to-back frames need no gap. Line buffer contents from the previous frame are harmless because of the row/col gating.
- Arithmetic: no pixel arithmetic. The counters are $clog2(IMG_W) and $clog2(IMG_H) bits wide.

## Timing
- Reset (rst=0, asynchronous), regardless of activity:
  - row, col, win_valid, frame_done, ifmap and the window register go to 0.
  - pix_ready = 1 after reset.
  - Line buffer storage need not be cleared.
- A window that is pending when reset asserts is dropped. Reset mid-frame restarts at (0,0).
- Latency: the window for the pixel accepted at edge N is valid after edge N, with registered output and no combinational path from pixel_in to ifmap.
- Throughput: one pixel per cycle with win_ready held high.
- ifmap is stable while win_valid && !win_ready.
- frame_done is registered: high for exactly the one cycle after the accepting edge.

## Structure
- Shared package holds DATA_W, KERNEL_DIM=3, WIN_W=KERNEL_DIM*KERNEL_DIM*DATA_W, and the byte-index function k=3*r+c. The PE tensor's filter packing uses the same indexing.
- Sub-module line_buffer: IMG_W-deep shift FIFO with shift enable, DATA_W data and tap output. It is instantiated twice.
- The counters, window register and handshake stay in the top module.

## Test plan
- 8x8 ramp frame, pixel = 8*row+col, win_ready=1 → first window after accepting pixel 18. ifmap bytes 0..8 = 0,1,2,8,9,10,16,17,18; exactly 36 windows.
- Same frame → last window bytes 0..8 = 45,46,47,53,54,55,61,62,63. frame_done is one pulse, on the cycle after pixel 63 is accepted.
- win_ready low for 5 cycles at window 10 → pix_ready=0 throughout, and ifmap is held unchanged. The window sequence is unchanged and there is no loss or duplication.
- Random pix_valid/win_ready gaps over 3 consecutive frames → 108 windows, each matching the reference model, with no gaps required between frames.
- rst pulsed low mid-frame at row 4 col 5 with win_valid=1 → outputs clear immediately. The next frame from (0,0) yields the correct first window 0,1,2,8,9,10,16,17,18.
- Row boundary: check that no window is emitted for pixels with col 0/1 (e.g. pixels 24, 25). The first window of row 3 contains 8,9,10,16,17,18,24,25,26.
